// File: rtl/traffic_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_monitor
//  Purpose  : Passive checker for one traffic-controller approach. Samples
//             the car light, pedestrian light and shared cycle count each
//             enabled clock, and flags conflicts, illegal codes, illegal
//             light sequences, short yellow/blink dwell and cycle-count
//             discontinuities.
//  Revision : 1.0 - initial release
// ============================================================================
module traffic_monitor #(
  parameter int CYCLE_MAX  = 68,
  parameter int MIN_YELLOW = 2,
  parameter int MIN_BLINK  = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [1:0]       i_car,
  input  logic [1:0]       i_ped,
  input  logic [6:0]       i_cycle,
  output logic             o_err,
  output logic [4:0]       o_err_code,
  output logic [4:0]       o_err_sticky,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic [15:0]      o_period_cnt
);

  // Light encodings
  localparam logic [1:0] c_car_red    = 2'b00;
  localparam logic [1:0] c_car_green  = 2'b01;
  localparam logic [1:0] c_car_yellow = 2'b10;
  localparam logic [1:0] c_car_left   = 2'b11;
  localparam logic [1:0] c_ped_red    = 2'b00;
  localparam logic [1:0] c_ped_green  = 2'b01;
  localparam logic [1:0] c_ped_blink  = 2'b10;
  localparam logic [1:0] c_ped_bad    = 2'b11;

  localparam logic [6:0]       c_cycle_max  = 7'(CYCLE_MAX);
  localparam logic [7:0]       c_min_yellow = 8'(MIN_YELLOW);
  localparam logic [7:0]       c_min_blink  = 8'(MIN_BLINK);
  localparam logic [CNT_W-1:0] c_cnt_sat    = {CNT_W{1'b1}};

  // Previous-sample history and counters
  logic [1:0]       r_prev_car;
  logic [1:0]       r_prev_ped;
  logic [6:0]       r_prev_cycle;
  logic [7:0]       r_dwell;
  logic             r_primed;
  logic [4:0]       r_err_code;
  logic [4:0]       r_err_sticky;
  logic [CNT_W-1:0] r_err_cnt;
  logic [15:0]      r_period_cnt;

  logic       w_conflict;
  logic       w_code;
  logic       w_car_ok;
  logic       w_ped_ok;
  logic       w_seq;
  logic       w_dwell_err;
  logic       w_cycle_err;
  logic       w_changed;
  logic       w_wrap;
  logic [6:0] w_cycle_exp;
  logic [7:0] w_dwell_nxt;
  logic [4:0] w_flags;

  // Legal car-light transitions (hold is always legal)
  always_comb begin
    w_car_ok = 1'b0;
    if (i_car == r_prev_car) begin
      w_car_ok = 1'b1;
    end else begin
      case ({r_prev_car, i_car})
        {c_car_red,    c_car_green}:  w_car_ok = 1'b1;
        {c_car_green,  c_car_left}:   w_car_ok = 1'b1;
        {c_car_green,  c_car_yellow}: w_car_ok = 1'b1;
        {c_car_left,   c_car_yellow}: w_car_ok = 1'b1;
        {c_car_yellow, c_car_red}:    w_car_ok = 1'b1;
        {c_car_red,    c_car_yellow}: w_car_ok = 1'b1;
        default:                      w_car_ok = 1'b0;
      endcase
    end
  end

  // Legal ped-light transitions; an illegal ped code is left to the CODE flag
  always_comb begin
    w_ped_ok = 1'b0;
    if (i_ped == c_ped_bad || i_ped == r_prev_ped) begin
      w_ped_ok = 1'b1;
    end else begin
      case ({r_prev_ped, i_ped})
        {c_ped_red,   c_ped_green}: w_ped_ok = 1'b1;
        {c_ped_green, c_ped_blink}: w_ped_ok = 1'b1;
        {c_ped_blink, c_ped_red}:   w_ped_ok = 1'b1;
        default:                    w_ped_ok = 1'b0;
      endcase
    end
  end

  // Per-sample violation flags; history-based checks wait for a primed sample
  always_comb begin
    w_conflict  = (i_car == c_car_green || i_car == c_car_left) &&
                  (i_ped == c_ped_green || i_ped == c_ped_blink);
    w_code      = (i_ped == c_ped_bad) || (i_cycle == 7'd0) || (i_cycle > c_cycle_max);
    w_seq       = r_primed && !(w_car_ok && w_ped_ok);
    w_dwell_err = r_primed &&
                  (((r_prev_car == c_car_yellow) && (i_car != c_car_yellow) && (r_dwell < c_min_yellow)) ||
                   ((r_prev_ped == c_ped_blink)  && (i_ped != c_ped_blink)  && (r_dwell < c_min_blink)));
    w_cycle_exp = (r_prev_cycle == c_cycle_max) ? 7'd1 : r_prev_cycle + 7'd1;
    w_cycle_err = r_primed && (i_cycle != w_cycle_exp);
    w_wrap      = r_primed && (r_prev_cycle == c_cycle_max) && (i_cycle == 7'd1);
    w_changed   = (i_car != r_prev_car) || (i_ped != r_prev_ped);
    w_flags     = {w_cycle_err, w_dwell_err, w_seq, w_code, w_conflict};
    if (!r_primed || w_changed) begin
      w_dwell_nxt = 8'd1;
    end else if (r_dwell != 8'hFF) begin
      w_dwell_nxt = r_dwell + 8'd1;
    end else begin
      w_dwell_nxt = r_dwell;
    end
  end

  // Sample history and per-sample flag register; disable forces re-priming
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_car   <= c_car_red;
      r_prev_ped   <= c_ped_red;
      r_prev_cycle <= 7'd0;
      r_dwell      <= 8'd0;
      r_primed     <= 1'b0;
      r_err_code   <= 5'd0;
    end else if (i_en) begin
      r_prev_car   <= i_car;
      r_prev_ped   <= i_ped;
      r_prev_cycle <= i_cycle;
      r_dwell      <= w_dwell_nxt;
      r_primed     <= 1'b1;
      r_err_code   <= w_flags;
    end else begin
      r_primed     <= 1'b0;
      r_err_code   <= 5'd0;
    end
  end

  // Sticky flags, saturating error count and period count; clear wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_sticky <= 5'd0;
      r_err_cnt    <= '0;
      r_period_cnt <= 16'd0;
    end else if (i_clr) begin
      r_err_sticky <= 5'd0;
      r_err_cnt    <= '0;
      r_period_cnt <= 16'd0;
    end else if (i_en) begin
      r_err_sticky <= r_err_sticky | w_flags;
      if ((|w_flags) && (r_err_cnt != c_cnt_sat)) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
      if (w_wrap) begin
        r_period_cnt <= r_period_cnt + 16'd1;
      end
    end
  end

  assign o_err        = |r_err_code;
  assign o_err_code   = r_err_code;
  assign o_err_sticky = r_err_sticky;
  assign o_err_cnt    = r_err_cnt;
  assign o_period_cnt = r_period_cnt;

endmodule
`default_nettype wire

// File: tb/tb_traffic_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_traffic_monitor
//  Purpose  : Directed self-checking bench for traffic_monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_monitor;

  localparam logic [1:0] c_red    = 2'b00;
  localparam logic [1:0] c_green  = 2'b01;
  localparam logic [1:0] c_yellow = 2'b10;
  localparam logic [1:0] c_left   = 2'b11;
  localparam logic [1:0] c_blink  = 2'b10;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_en;
  logic        i_clr;
  logic [1:0]  i_car;
  logic [1:0]  i_ped;
  logic [6:0]  i_cycle;
  logic        o_err;
  logic [4:0]  o_err_code;
  logic [4:0]  o_err_sticky;
  logic [7:0]  o_err_cnt;
  logic [15:0] o_period_cnt;

  int checks = 0;
  int errors = 0;

  traffic_monitor #(
    .CYCLE_MAX (68),
    .MIN_YELLOW(2),
    .MIN_BLINK (2),
    .CNT_W     (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_en        (i_en),
    .i_clr       (i_clr),
    .i_car       (i_car),
    .i_ped       (i_ped),
    .i_cycle     (i_cycle),
    .o_err       (o_err),
    .o_err_code  (o_err_code),
    .o_err_sticky(o_err_sticky),
    .o_err_cnt   (o_err_cnt),
    .o_period_cnt(o_period_cnt)
  );

  always #5 clk = ~clk;

  // Clean mode-0 schedule
  function automatic logic [1:0] car_of(input int c);
    if (c <= 22)      return c_green;
    else if (c <= 32) return c_left;
    else if (c <= 34) return c_yellow;
    else              return c_red;
  endfunction

  function automatic logic [1:0] ped_of(input int c);
    if (c <= 34)      return c_red;
    else if (c <= 48) return c_green;
    else if (c <= 54) return c_blink;
    else              return c_red;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one sample and move to #1 after the edge that captures it
  task automatic step(input logic en, input logic clr, input logic [1:0] car,
                      input logic [1:0] ped, input logic [6:0] cyc);
    i_en    = en;
    i_clr   = clr;
    i_car   = car;
    i_ped   = ped;
    i_cycle = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic clean(input int c);
    step(1'b1, 1'b0, car_of(c), ped_of(c), 7'(c));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; i_en = 1'b0; i_clr = 1'b0;
    i_car = c_red; i_ped = c_red; i_cycle = 7'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_err",    32'(o_err), 32'd0);
    chk("rst_code",   32'(o_err_code), 32'd0);
    chk("rst_sticky", 32'(o_err_sticky), 32'd0);
    chk("rst_cnt",    32'(o_err_cnt), 32'd0);
    chk("rst_period", 32'(o_period_cnt), 32'd0);
    rst = 1'b0;

    // Three clean periods plus the wrap into a fourth
    for (int p = 0; p < 3; p++) begin
      for (int c = 1; c <= 68; c++) begin
        clean(c);
        chk("clean_err", 32'(o_err), 32'd0);
      end
    end
    clean(1);
    chk("clean_sticky", 32'(o_err_sticky), 32'd0);
    chk("clean_cnt",    32'(o_err_cnt), 32'd0);
    chk("clean_period", 32'(o_period_cnt), 32'd3);

    // Conflict at cycle 10, then disable for one cycle to end the pulse
    for (int c = 2; c <= 9; c++) clean(c);
    step(1'b1, 1'b0, c_green, c_green, 7'd10);
    chk("conf_err",  32'(o_err), 32'd1);
    chk("conf_code", 32'(o_err_code), 32'b00001);
    chk("conf_cnt",  32'(o_err_cnt), 32'd1);
    step(1'b0, 1'b0, c_green, c_red, 7'd11);
    chk("conf_pulse_end", 32'(o_err), 32'd0);
    chk("conf_cnt_hold",  32'(o_err_cnt), 32'd1);

    // Re-prime at 12, then GREEN->RED at 23
    for (int c = 12; c <= 22; c++) clean(c);
    chk("pre_seq_err", 32'(o_err), 32'd0);
    step(1'b1, 1'b0, c_red, c_red, 7'd23);
    chk("seq_code", 32'(o_err_code), 32'b00100);
    chk("seq_cnt",  32'(o_err_cnt), 32'd2);
    step(1'b1, 1'b0, c_red, c_red, 7'd24);
    chk("hold_err", 32'(o_err), 32'd0);
    // Yellow for one cycle only
    step(1'b1, 1'b0, c_yellow, c_red, 7'd25);
    chk("yel_err", 32'(o_err), 32'd0);
    step(1'b1, 1'b0, c_red, c_red, 7'd26);
    chk("dwell_code",   32'(o_err_code), 32'b01000);
    chk("dwell_cnt",    32'(o_err_cnt), 32'd3);
    chk("dwell_sticky", 32'(o_err_sticky), 32'b01101);

    // Clear
    step(1'b1, 1'b1, c_red, c_red, 7'd27);
    chk("clr_err",    32'(o_err), 32'd0);
    chk("clr_cnt",    32'(o_err_cnt), 32'd0);
    chk("clr_sticky", 32'(o_err_sticky), 32'd0);
    chk("clr_period", 32'(o_period_cnt), 32'd0);

    // Cycle sequence 5,6,9,10 then 69
    step(1'b0, 1'b0, c_red, c_red, 7'd0);
    step(1'b1, 1'b0, c_red, c_red, 7'd5);
    chk("cyc5_err", 32'(o_err), 32'd0);
    step(1'b1, 1'b0, c_red, c_red, 7'd6);
    chk("cyc6_err", 32'(o_err), 32'd0);
    step(1'b1, 1'b0, c_red, c_red, 7'd9);
    chk("cyc9_code", 32'(o_err_code), 32'b10000);
    step(1'b1, 1'b0, c_red, c_red, 7'd10);
    chk("cyc10_err", 32'(o_err), 32'd0);
    chk("cyc10_cnt", 32'(o_err_cnt), 32'd1);
    step(1'b1, 1'b0, c_red, c_red, 7'd69);
    chk("cyc69_code", 32'(o_err_code), 32'b10010);
    chk("cyc69_cnt",  32'(o_err_cnt), 32'd2);

    // 300 conflict samples with a continuous cycle count
    step(1'b0, 1'b0, c_red, c_red, 7'd0);
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 1'b0, c_green, c_green, 7'((i % 68) + 1));
      if (i == 0)   chk("sat_first_code", 32'(o_err_code), 32'b00001);
      if (i == 254) chk("sat_cnt_255",    32'(o_err_cnt), 32'd255);
    end
    chk("sat_cnt",    32'(o_err_cnt), 32'd255);
    chk("sat_sticky", 32'(o_err_sticky), 32'b10011);
    chk("sat_period", 32'(o_period_cnt), 32'd4);

    // Fresh clean run to cycle 40, then asynchronous reset
    step(1'b0, 1'b0, c_red, c_red, 7'd0);
    for (int c = 1; c <= 40; c++) clean(c);
    chk("pre_rst_cnt", 32'(o_err_cnt), 32'd255);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_err",    32'(o_err), 32'd0);
    chk("arst_code",   32'(o_err_code), 32'd0);
    chk("arst_sticky", 32'(o_err_sticky), 32'd0);
    chk("arst_cnt",    32'(o_err_cnt), 32'd0);
    chk("arst_period", 32'(o_period_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clean(41);
    chk("post_rst_code", 32'(o_err_code), 32'd0);
    clean(42);
    chk("post_rst_next", 32'(o_err_code), 32'd0);

    // Disabled for 5 cycles with a jumping cycle count
    step(1'b0, 1'b0, c_green, c_green, 7'd7);
    chk("dis0_err", 32'(o_err), 32'd0);
    step(1'b0, 1'b0, c_left,  c_blink, 7'd60);
    chk("dis1_err", 32'(o_err), 32'd0);
    step(1'b0, 1'b0, c_red,   2'b11,   7'd3);
    chk("dis2_err", 32'(o_err), 32'd0);
    step(1'b0, 1'b0, c_green, c_red,   7'd99);
    chk("dis3_err", 32'(o_err), 32'd0);
    step(1'b0, 1'b0, c_yellow, c_red,  7'd20);
    chk("dis4_err", 32'(o_err), 32'd0);
    clean(10);
    chk("reen_code", 32'(o_err_code), 32'd0);
    clean(11);
    chk("reen_next", 32'(o_err_code), 32'd0);

    // Clear in the same cycle as an error
    step(1'b1, 1'b1, c_green, c_green, 7'd12);
    chk("clrerr_err",    32'(o_err), 32'd1);
    chk("clrerr_code",   32'(o_err_code), 32'b00001);
    chk("clrerr_cnt",    32'(o_err_cnt), 32'd0);
    chk("clrerr_sticky", 32'(o_err_sticky), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
